pipeline_w_skid: RTL and testbench
==================================

// Module: pipeline_w_skid
// PURPOSE
//  MEM->WB pipeline register with valid/ready handshake and 2-entry skid buffer.
//  Sits between the memory stage and the register-file write port.
//  Replaces the plain always-latching register so that:
//   - writeback can back-pressure (w_ready low), e.g. on write-port contention;
//   - the stage can be flushed;
//   - register writes are only issued for valid entries.
// PARAMETERS
//  DATA_WIDTH       32  width of ALU result and read data
//  ADDRESS_WIDTH    32  width of PC+4
//  REG_ADDR_WIDTH   5   destination register index width
//  RESULTSRC_WIDTH  2   result-select field width
//  ZERO_RD_SUPPRESS 1   1: force w_regwrite=0 when w_rd==0
// PORTS
//  clk          in   1                clock; all state changes on posedge
//  rst_n        in   1                synchronous reset, active low
//  flush        in   1                drop all buffered entries
//  m_valid      in   1                memory stage presents an entry
//  m_ready      out  1                stage can accept an entry this cycle
//  m_aluresult  in   DATA_WIDTH       ALU result
//  m_readdata   in   DATA_WIDTH       data-memory read data
//  m_rd         in   REG_ADDR_WIDTH   destination register
//  m_pcplus4    in   ADDRESS_WIDTH    PC+4
//  m_regwrite   in   1                register write enable
//  m_resultsrc  in   RESULTSRC_WIDTH  result select
//  w_valid      out  1                head entry valid
//  w_ready      in   1                writeback consumes head this cycle
//  w_aluresult, w_readdata, w_rd, w_pcplus4, w_resultsrc
//               out  (as m_*)         head entry fields
//  w_regwrite   out  1                w_valid & head.regwrite (& rd!=0 if ZERO_RD_SUPPRESS)
//  w_count      out  2                occupancy: 0, 1 or 2
// BEHAVIOUR
//  - Handshakes: push = m_valid & m_ready; pop = w_valid & w_ready.
//  - Storage: head register (drives w_*) and skid register.
//  - States: EMPTY(count 0), ONE(1), FULL(2).
//  - m_ready = rst_n & (state!=FULL). It is decoded from state only; there is no
//    combinational path from w_ready.
//  - w_valid = (state!=EMPTY).
//  - EMPTY: push -> ONE, head<=m_*. Latency is 1 cycle from push to w_valid.
//  - ONE:
//     push&pop  -> ONE,  head<=m_*
//     push only -> FULL, skid<=m_*
//     pop only  -> EMPTY
//  - FULL: m_ready=0, so no push.
//     pop -> ONE, head<=skid
//  - Ordering: strictly FIFO. No entry is duplicated or lost except by flush or reset.
//  - Data outputs while w_valid=0 hold their last value. w_regwrite is 0 in that case.
//  - flush=1 (sampled at posedge):
//     next state EMPTY;
//     any push in that cycle is discarded;
//     any pop in that cycle still counts as consumed;
//     stored data fields are not cleared.
//  - Reset (rst_n=0 at posedge), including mid-operation:
//     state EMPTY;
//     all w_* data fields 0;
//     w_valid=0, w_regwrite=0, w_count=0;
//     m_ready=0 while rst_n=0.
//  - Priority: rst_n over flush over push/pop.
//  - No arithmetic on payload; fields pass bit-exact.
// TESTING
//  1. Reset, then push {alu=0x1234,rd=5,regwrite=1}, w_ready=1
//     -> next cycle w_valid=1, w_aluresult=0x1234, w_regwrite=1, w_count=1.
//  2. w_ready=0; push A,B
//     -> w_count=2, m_ready=0; push C held off.
//     Then w_ready=1 -> outputs A, B, C in order, no gaps beyond the stall.
//  3. Streaming: m_valid=1, w_ready=1 for 10 cycles, PC+4 = 4,8,...,40
//     -> w_pcplus4 follows 1 cycle later, count stays 1.
//  4. FULL + flush=1 with m_valid=1
//     -> next cycle w_valid=0, w_count=0, incoming entry absent.
//  5. Push rd=0, regwrite=1 -> w_valid=1, w_regwrite=0 (ZERO_RD_SUPPRESS=1).
//  6. rst_n=0 while FULL -> next cycle all outputs 0, m_ready=0.
//     Release rst_n -> m_ready=1, w_valid=0.

Source files
------------

// File: rtl/pipeline_w_skid.sv
// pipeline_w_skid: MEM->WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
module pipeline_w_skid #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_WIDTH    = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int RESULTSRC_WIDTH  = 2,
  parameter bit ZERO_RD_SUPPRESS = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       m_valid,
  output logic                       m_ready,
  input  logic [DATA_WIDTH-1:0]      m_aluresult,
  input  logic [DATA_WIDTH-1:0]      m_readdata,
  input  logic [REG_ADDR_WIDTH-1:0]  m_rd,
  input  logic [ADDRESS_WIDTH-1:0]   m_pcplus4,
  input  logic                       m_regwrite,
  input  logic [RESULTSRC_WIDTH-1:0] m_resultsrc,
  output logic                       w_valid,
  input  logic                       w_ready,
  output logic [DATA_WIDTH-1:0]      w_aluresult,
  output logic [DATA_WIDTH-1:0]      w_readdata,
  output logic [REG_ADDR_WIDTH-1:0]  w_rd,
  output logic [ADDRESS_WIDTH-1:0]   w_pcplus4,
  output logic                       w_regwrite,
  output logic [RESULTSRC_WIDTH-1:0] w_resultsrc,
  output logic [1:0]                 w_count
);
  localparam int PW = 2*DATA_WIDTH + REG_ADDR_WIDTH + ADDRESS_WIDTH + 1 + RESULTSRC_WIDTH;
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]    r_state;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_skid;
  logic [1:0]    w_nxt_state;
  logic [PW-1:0] w_in;
  logic [PW-1:0] w_head_d;
  logic          w_push;
  logic          w_pop;
  logic          w_load_head;
  logic          w_load_skid;
  logic          w_head_rw;
  assign w_in = {m_aluresult, m_readdata, m_rd, m_pcplus4, m_regwrite, m_resultsrc};
  assign {w_aluresult, w_readdata, w_rd, w_pcplus4, w_head_rw, w_resultsrc} = r_head;
  // m_ready comes from state alone, so there is no combinational path from w_ready
  assign m_ready    = rst_n & (r_state != FULL);
  assign w_valid    = r_state != EMPTY;
  assign w_count    = r_state;
  assign w_regwrite = w_valid & w_head_rw & (!ZERO_RD_SUPPRESS | (w_rd != '0));
  assign w_push     = m_valid & m_ready;
  assign w_pop      = w_valid & w_ready;
  always_comb begin
    w_load_head = !flush & ((r_state == EMPTY & w_push) | (r_state == ONE & w_push & w_pop) |
                            (r_state == FULL & w_pop));
    w_load_skid = !flush & r_state == ONE & w_push & !w_pop;
    w_head_d    = r_state == FULL ? r_skid : w_in;
    w_nxt_state = flush              ? EMPTY :
                  r_state == EMPTY   ? (w_push ? ONE : EMPTY) :
                  r_state == ONE     ? (w_push & !w_pop ? FULL : !w_push & w_pop ? EMPTY : ONE) :
                                       (w_pop ? ONE : FULL);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_load_head) r_head <= w_head_d;
      if (w_load_skid) r_skid <= w_in;
    end
  end
endmodule

// File: tb/tb_pipeline_w_skid.sv
// tb_pipeline_w_skid: directed checks of the MEM->WB skid register.
module tb_pipeline_w_skid;
  logic        clk = 1'b0;
  logic        rst_n, flush, m_valid, m_ready, m_regwrite, w_valid, w_ready, w_regwrite;
  logic [31:0] m_aluresult, m_readdata, m_pcplus4, w_aluresult, w_readdata, w_pcplus4;
  logic [4:0]  m_rd, w_rd;
  logic [1:0]  m_resultsrc, w_resultsrc, w_count;
  int          n_vec = 0;
  int          n_err = 0;

  pipeline_w_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_aluresult(m_aluresult), .m_readdata(m_readdata), .m_rd(m_rd), .m_pcplus4(m_pcplus4),
    .m_regwrite(m_regwrite), .m_resultsrc(m_resultsrc), .w_valid(w_valid), .w_ready(w_ready),
    .w_aluresult(w_aluresult), .w_readdata(w_readdata), .w_rd(w_rd), .w_pcplus4(w_pcplus4),
    .w_regwrite(w_regwrite), .w_resultsrc(w_resultsrc), .w_count(w_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [4:0] rd, input logic [31:0] pc, input logic rw,
                       input logic [1:0] rs);
    m_valid = v; m_aluresult = alu; m_readdata = rdat; m_rd = rd;
    m_pcplus4 = pc; m_regwrite = rw; m_resultsrc = rs;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; w_ready = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 1'b0, 2'd0);
    tick(); tick();
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_count", w_count, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_alu", w_aluresult, 0);
    chk("rst_regwrite", w_regwrite, 0);
    rst_n = 1'b1; #1;
    chk("rel_m_ready", m_ready, 1);
    // single push, 1-cycle latency, then pop leaves data held
    drive(1'b1, 32'h1234, 0, 5'd5, 32'h0, 1'b1, 2'd0); w_ready = 1'b1;
    tick(); m_valid = 1'b0;
    chk("t1_w_valid", w_valid, 1);
    chk("t1_alu", w_aluresult, 32'h1234);
    chk("t1_regwrite", w_regwrite, 1);
    chk("t1_count", w_count, 1);
    tick();
    chk("t1_pop_count", w_count, 0);
    chk("t1_pop_regwrite", w_regwrite, 0);
    chk("t1_hold_alu", w_aluresult, 32'h1234);
    // back-pressure: A, B fill, C held off
    w_ready = 1'b0;
    drive(1'b1, 32'hA, 32'hA0, 5'd1, 32'h100, 1'b1, 2'd1); tick();
    drive(1'b1, 32'hB, 32'hB0, 5'd2, 32'h104, 1'b1, 2'd2); tick();
    chk("t2_count2", w_count, 2);
    chk("t2_m_ready", m_ready, 0);
    drive(1'b1, 32'hC, 32'hC0, 5'd3, 32'h108, 1'b0, 2'd3); tick();
    chk("t2_held_count", w_count, 2);
    chk("t2_head_A", w_aluresult, 32'hA);
    w_ready = 1'b1; tick();
    chk("t2_head_B", w_aluresult, 32'hB);
    chk("t2_B_rdata", w_readdata, 32'hB0);
    chk("t2_B_rd", w_rd, 2);
    chk("t2_B_rs", w_resultsrc, 2);
    chk("t2_B_count", w_count, 1);
    tick(); m_valid = 1'b0;
    chk("t2_head_C", w_aluresult, 32'hC);
    chk("t2_C_pc", w_pcplus4, 32'h108);
    chk("t2_C_regwrite", w_regwrite, 0);
    tick();
    chk("t2_drain", w_count, 0);
    // streaming at one entry per cycle
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, i, 0, 5'd7, 4*i, 1'b1, 2'd0); tick();
      chk("t3_pc", w_pcplus4, 4*i);
      chk("t3_count", w_count, 1);
    end
    m_valid = 1'b0; tick();
    chk("t3_drain", w_count, 0);
    // flush while FULL with an incoming entry
    w_ready = 1'b0;
    drive(1'b1, 32'hD, 0, 5'd4, 32'h200, 1'b1, 2'd0); tick();
    drive(1'b1, 32'hE, 0, 5'd4, 32'h204, 1'b1, 2'd0); tick();
    chk("t4_full", w_count, 2);
    drive(1'b1, 32'hF, 0, 5'd4, 32'h208, 1'b1, 2'd0); flush = 1'b1; tick();
    flush = 1'b0; m_valid = 1'b0;
    chk("t4_w_valid", w_valid, 0);
    chk("t4_count", w_count, 0);
    chk("t4_regwrite", w_regwrite, 0);
    chk("t4_hold_alu", w_aluresult, 32'hD);
    // flush with an accepted push in ONE discards that push
    drive(1'b1, 32'h6, 0, 5'd4, 32'h300, 1'b1, 2'd0); tick();
    chk("t4b_one", w_count, 1);
    drive(1'b1, 32'h7, 0, 5'd4, 32'h304, 1'b1, 2'd0); flush = 1'b1; tick();
    flush = 1'b0; m_valid = 1'b0;
    chk("t4b_count", w_count, 0);
    tick();
    chk("t4b_absent", w_valid, 0);
    chk("t4b_hold_alu", w_aluresult, 32'h6);
    // rd=0 suppresses the register write
    drive(1'b1, 32'h55, 0, 5'd0, 32'h400, 1'b1, 2'd0); tick(); m_valid = 1'b0;
    chk("t5_w_valid", w_valid, 1);
    chk("t5_regwrite", w_regwrite, 0);
    w_ready = 1'b1; tick();
    chk("t5_drain", w_count, 0);
    // reset while FULL
    w_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h22, 5'd9, 32'h500, 1'b1, 2'd3); tick(); tick();
    chk("t6_full", w_count, 2);
    rst_n = 1'b0; m_valid = 1'b0; tick();
    chk("t6_w_valid", w_valid, 0);
    chk("t6_count", w_count, 0);
    chk("t6_alu", w_aluresult, 0);
    chk("t6_rdata", w_readdata, 0);
    chk("t6_rd", w_rd, 0);
    chk("t6_pc", w_pcplus4, 0);
    chk("t6_rs", w_resultsrc, 0);
    chk("t6_regwrite", w_regwrite, 0);
    chk("t6_m_ready", m_ready, 0);
    rst_n = 1'b1; #1;
    chk("t6_rel_m_ready", m_ready, 1);
    chk("t6_rel_w_valid", w_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
